dfr0520_spi_master: RTL and testbench
=====================================

# dfr0520_spi_master

SPI write-only master for the DFRobot DFR0520 dual digital potentiometer (MCP42xxx device). On a start strobe it captures a 2-bit command, 2-bit channel select and 8-bit data value, then shifts a 16-bit frame to the device over CS/SCK/MOSI. It sits between control logic that decides wiper settings and the board-level SPI pins.

## Interface
- SCK_HALF, 1: clk_in cycles per SCK half-period (≥1).
- CS_GAP, 2: minimum clk_in cycles CS stays high between frames (≥1).
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- EN  input  1  start strobe; a rising edge (high this cycle, low last cycle) requests a frame.
- cmd  input  2  device command bits C1:C0 (01 write, 10 shutdown, 00/11 no-op).
- sel  input  2  pot select P1:P0 (01 pot0, 10 pot1, 11 both).
- data  input  8  wiper value.
- CS  output  1  chip select, active low.
- SCK  output  1  serial clock, idle low (SPI mode 0,0).
- MOSI  output  1  serial data, MSB first.
- busy  output  1  high from the cycle after a start is accepted until return to IDLE.

## Operation
- Frame = {2'b00, cmd, 2'b00, sel, data}, 16 bits, bit 15 first. cmd/sel values go out verbatim, including no-op/00 codes.
- cmd, sel, data captured on the cycle EN's rising edge is sampled; later input changes do not affect the frame in flight.
- States: IDLE, LEAD, SHIFT, GAP.
- IDLE: CS=1, SCK=0, MOSI=0. On EN rising edge: load shift register, go to LEAD.
- LEAD: CS=0, SCK=0, MOSI=frame[15], for SCK_HALF cycles.
- SHIFT: per bit, SCK high SCK_HALF cycles then low SCK_HALF cycles; MOSI updates to the next bit on the same edge SCK goes low. After bit 0's low phase, go to GAP.
- GAP: CS=1, SCK=0, MOSI=0 for CS_GAP cycles; then start the pending request if one exists (into LEAD), else IDLE.
- Pending request: one-deep. An EN rising edge while busy captures cmd/sel/data into a pending slot; a further rising edge while pending is full overwrites it (latest wins). No request is ever dropped except by overwrite or reset.
- Holding EN high produces exactly one frame.

## Timing
- All outputs registered. EN rising sampled at edge k → CS low, MOSI=bit15 after edge k+1.
- CS low for 33·SCK_HALF cycles; 16 SCK rising edges; first SCK rise SCK_HALF cycles after CS falls.
- MOSI stable SCK_HALF cycles before and after each SCK rising edge.
- Default params: frame 33 cycles CS low + 2 cycles gap = 35 cycles start-to-start when back-to-back.
- Reset (any state, including mid-frame): next edge CS=1, SCK=0, MOSI=0, busy=0, pending cleared, EN edge detector cleared to 0 (EN high during reset release counts as a rising edge only after it has been seen low).
- EN rising in the same cycle rst is high: ignored.
- EN rising during GAP: becomes pending, started at end of GAP.

## Test plan
- Reset, idle: rst 2 cycles -> CS=1, SCK=0, MOSI=0, busy=0, no SCK activity.
- Single write: cmd=01, sel=01, data=0xAA, 1-cycle EN pulse -> CS low 33 cycles, 16 SCK rises, MOSI bits sampled on SCK rise = 0x11AA.
- Input change mid-frame: data→0xF1 6 cycles after start -> frame still 0x11AA.
- Queued request: second EN pulse with data=0xF1 while first frame busy -> after 2-cycle CS-high gap, second frame 0x11F1; total 2 frames.
- Level EN: EN held high 100 cycles, cmd=10, sel=11, data=0x00 -> exactly one frame 0x2300.
- Reset mid-frame: rst at bit 8 -> CS=1 next edge, no further SCK, pending discarded, next EN gives full frame.

Source files
------------

// File: rtl/dfr0520_spi_master.sv
// Write-only SPI master for the MCP42xxx dual digital potentiometer (DFR0520).
// Sends {2'b00, cmd, 2'b00, sel, data} MSB first in mode 0,0 and holds one queued request.
module dfr0520_spi_master #(
  parameter int SCK_HALF = 1,
  parameter int CS_GAP   = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       EN,
  input  logic [1:0] cmd,
  input  logic [1:0] sel,
  input  logic [7:0] data,
  output logic       CS,
  output logic       SCK,
  output logic       MOSI,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  state_t      r_state, w_state_nx;
  logic [15:0] r_shift, r_pend, r_cnt;
  logic        r_pend_v, r_en_d, r_armed, r_ph;
  logic [3:0]  r_bit;
  logic        r_cs, r_sck, r_mosi, r_busy;

  logic        w_rise, w_half_done, w_gap_done, w_load, w_cnt_clr;
  logic        w_cs, w_sck, w_mosi, w_busy;
  logic [15:0] w_frame_in;

  // EN held high across reset release must be seen low before it can start a frame.
  assign w_rise      = EN && !r_en_d && r_armed;
  assign w_half_done = (r_cnt == 16'(SCK_HALF - 1));
  assign w_gap_done  = (r_cnt == 16'(CS_GAP - 1));
  assign w_frame_in  = {2'b00, cmd, 2'b00, sel, data};

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:  if (w_rise) w_state_nx = LEAD;
      LEAD:  if (w_half_done) w_state_nx = SHIFT;
      SHIFT: if (w_half_done && r_ph && (r_bit == 4'd0)) w_state_nx = GAP;
      GAP:   if (w_gap_done) w_state_nx = (r_pend_v || w_rise) ? LEAD : IDLE;
      default: w_state_nx = IDLE;
    endcase
    w_load    = (w_state_nx == LEAD) && (r_state != LEAD);
    w_cnt_clr = (w_state_nx != r_state) || (r_state == IDLE) ||
                ((r_state == SHIFT) && w_half_done);
    w_cs      = !((r_state == LEAD) || (r_state == SHIFT));
    w_sck     = (r_state == SHIFT) && !r_ph;
    w_mosi    = w_cs ? 1'b0 : r_shift[15];
    w_busy    = (r_state != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_shift  <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_ph     <= 1'b0;
      r_en_d   <= 1'b0;
      r_armed  <= !EN;
      r_cs     <= 1'b1;
      r_sck    <= 1'b0;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_en_d  <= EN;
      r_armed <= r_armed || !EN;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + 16'd1;

      // A rise coinciding with a load from GAP is newer than the pending slot, so it wins.
      if (w_load) begin
        r_shift  <= w_rise ? w_frame_in : r_pend;
        r_pend_v <= 1'b0;
        r_bit    <= 4'd15;
        r_ph     <= 1'b0;
      end else begin
        if (w_rise && (r_state != IDLE)) begin
          r_pend   <= w_frame_in;
          r_pend_v <= 1'b1;
        end
        if ((r_state == SHIFT) && w_half_done) begin
          if (!r_ph) begin
            r_shift <= {r_shift[14:0], 1'b0};
            r_ph    <= 1'b1;
          end else begin
            r_ph  <= 1'b0;
            r_bit <= r_bit - 4'd1;
          end
        end
      end

      r_cs   <= w_cs;
      r_sck  <= w_sck;
      r_mosi <= w_mosi;
      r_busy <= w_busy;
    end
  end

  assign CS   = r_cs;
  assign SCK  = r_sck;
  assign MOSI = r_mosi;
  assign busy = r_busy;

endmodule

// File: tb/tb_dfr0520_spi_master.sv
// Bench for dfr0520_spi_master: a pin-level monitor decodes frames, compared against
// frames predicted from the request sequence (first request plus latest queued one).
module tb_dfr0520_spi_master;

  localparam int SCK_HALF = 1;
  localparam int CS_GAP   = 2;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       EN = 1'b0;
  logic [1:0] cmd = '0;
  logic [1:0] sel = '0;
  logic [7:0] data = '0;
  logic       CS, SCK, MOSI, busy;

  dfr0520_spi_master #(.SCK_HALF(SCK_HALF), .CS_GAP(CS_GAP)) dut (
    .clk_in(clk_in), .rst(rst), .EN(EN), .cmd(cmd), .sel(sel), .data(data),
    .CS(CS), .SCK(SCK), .MOSI(MOSI), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] val;
    int          rises;
    int          len;
    int          gap;
  } frame_t;

  frame_t      q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          total_rises = 0;
  int          cur_rises = 0;
  int          cur_len = 0;
  int          hi_cnt = 0;
  int          cur_gap = 0;
  logic [15:0] cur_bits = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mk_frame(input logic [1:0] c, input logic [1:0] s,
                                           input logic [7:0] d);
    return {2'b00, c, 2'b00, s, d};
  endfunction

  // Pin-level monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk_in) begin
    if (SCK && !prev_sck) total_rises++;
    if (!CS) begin
      if (prev_cs) begin
        cur_gap   = hi_cnt;
        cur_bits  = '0;
        cur_rises = 0;
        cur_len   = 0;
      end
      cur_len++;
      if (SCK && !prev_sck) begin
        cur_bits = {cur_bits[14:0], MOSI};
        cur_rises++;
      end
    end else begin
      if (!prev_cs) begin
        q.push_back('{val: cur_bits, rises: cur_rises, len: cur_len, gap: cur_gap});
        hi_cnt = 0;
      end
      hi_cnt++;
    end
    prev_cs  = CS;
    prev_sck = SCK;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic pulse(input logic [1:0] c, input logic [1:0] s, input logic [7:0] d);
    cmd = c; sel = s; data = d; EN = 1'b1;
    tick(1);
    EN = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int t = 0;
    while (q.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check(tag, 32'(q.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [15:0] exp,
                             input bit chk_gap);
    if (idx >= q.size()) begin
      check({tag, "_present"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_val"}, 32'(q[idx].val), 32'(exp));
    check({tag, "_rises"}, 32'(q[idx].rises), 32'd16);
    check({tag, "_cslow"}, 32'(q[idx].len), 32'(33 * SCK_HALF));
    if (chk_gap) check({tag, "_gap"}, 32'(q[idx].gap), 32'(CS_GAP));
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [1:0]  c;
    logic [1:0]  s;
    logic [7:0]  d;
    int          n_extra;
    int          base;

    // Reset and idle
    tick(2);
    rst = 1'b0;
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_sck", 32'(SCK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(20);
    check("idle_no_sck", 32'(total_rises), 32'd0);
    check("idle_no_frame", 32'(q.size()), 32'd0);

    // Single write, mid-frame input change, queued second request
    pulse(2'b01, 2'b01, 8'hAA);
    tick(1);
    check("start_cs", 32'(CS), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    tick(4);
    data = 8'hF1;
    pulse(2'b01, 2'b01, 8'hF1);
    data = 8'h00;
    wait_frames("wait_queued", 2, 200);
    check_frame("f_11AA", 0, 16'h11AA, 1'b0);
    check_frame("f_11F1", 1, 16'h11F1, 1'b1);
    tick(40);
    check("queued_total", 32'(q.size()), 32'd2);
    check("queued_idle_busy", 32'(busy), 32'd0);
    q.delete();

    // Level EN gives one frame
    cmd = 2'b10; sel = 2'b11; data = 8'h00; EN = 1'b1;
    tick(100);
    EN = 1'b0;
    tick(60);
    check("level_count", 32'(q.size()), 32'd1);
    check_frame("f_2300", 0, 16'h2300, 1'b0);
    q.delete();

    // Reset at bit 8 with a queued request discarded
    pulse(2'b01, 2'b10, 8'h5C);
    tick(5);
    pulse(2'b01, 2'b11, 8'h3E);
    base = 0;
    while (cur_rises < 8 && base < 100) begin
      tick(1);
      base++;
    end
    check("reach_bit8", 32'(cur_rises), 32'd8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_cs", 32'(CS), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    base = total_rises;
    tick(100);
    check("midrst_no_sck", 32'(total_rises), 32'(base));
    check("midrst_partial", 32'(q.size()), 32'd1);
    if (q.size() > 0) check("midrst_rises", 32'(q[0].rises), 32'd8);
    q.delete();
    pulse(2'b01, 2'b10, 8'h77);
    wait_frames("wait_after_rst", 1, 100);
    check_frame("f_after_rst", 0, 16'h1277, 1'b0);
    tick(10);
    q.delete();

    // Randomized requests: first frame plus the latest queued one
    for (int it = 0; it < 10; it++) begin
      exp_q.delete();
      c = 2'($urandom); s = 2'($urandom); d = 8'($urandom);
      pulse(c, s, d);
      exp_q.push_back(mk_frame(c, s, d));
      n_extra = $urandom_range(0, 2);
      tick($urandom_range(4, 10));
      for (int k = 0; k < n_extra; k++) begin
        c = 2'($urandom); s = 2'($urandom); d = 8'($urandom);
        pulse(c, s, d);
        tick($urandom_range(2, 6));
      end
      if (n_extra > 0) exp_q.push_back(mk_frame(c, s, d));
      cmd = 2'($urandom); sel = 2'($urandom); data = 8'($urandom);
      wait_frames($sformatf("wait_rnd%0d", it), exp_q.size(), 300);
      for (int k = 0; k < exp_q.size(); k++)
        check_frame($sformatf("rnd%0d_%0d", it, k), k, exp_q[k], k > 0);
      tick(40);
      check($sformatf("rnd%0d_count", it), 32'(q.size()), 32'(exp_q.size()));
      q.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
